// File: rtl/multi_port_sync_fifo_pkg.sv
// Shared definitions for multi_port_sync_fifo: the modular pointer-advance
// helper used by both pointer controllers and the read/write index decode,
// and the error-cause encoding used by the optional request checker.
package multi_port_sync_fifo_pkg;

  // Reason a request was rejected in the error-checking build.
  typedef enum logic [1:0] {
    NONE      = 2'd0,
    OVERFLOW  = 2'd1,
    UNDERFLOW = 2'd2
  } err_cause_e;

  // Advance ptr by n entries modulo depth. Callers guarantee ptr < depth and
  // n <= depth, so a single conditional subtract is enough; this keeps
  // non-power-of-two depths exact.
  function automatic int unsigned ptr_advance(input int unsigned ptr,
                                              input int unsigned n,
                                              input int unsigned depth);
    int unsigned sum;
    sum = ptr + n;
    if (sum >= depth) begin
      return sum - depth;
    end else begin
      return sum;
    end
  endfunction

endpackage

// File: rtl/mpfifo_ptr_ctrl.sv
// One circular pointer of the FIFO (head or tail). Returns to entry 0 on
// reset or flush, otherwise advances by adv_i entries modulo Depth.
module mpfifo_ptr_ctrl
  import multi_port_sync_fifo_pkg::*;
#(
  parameter int unsigned Depth    = 16,
  parameter int unsigned AdvWidth = 2,
  localparam int unsigned PtrWidth = $clog2(Depth)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush_i,
  input  logic [AdvWidth-1:0] adv_i,
  output logic [PtrWidth-1:0] ptr_o
);

  logic [PtrWidth-1:0] ptr_r;
  logic [PtrWidth-1:0] ptr_nxt_s;

  // Candidate next pointer: wrap-aware advance by the granted lane count.
  always_comb begin
    ptr_nxt_s = PtrWidth'(ptr_advance(32'(ptr_r), 32'(adv_i), Depth));
  end

  // Pointer register: reset beats flush, flush beats advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r <= {PtrWidth{1'b0}};
    end else if (flush_i) begin
      ptr_r <= {PtrWidth{1'b0}};
    end else begin
      ptr_r <= ptr_nxt_s;
    end
  end

  assign ptr_o = ptr_r;

endmodule

// File: rtl/multi_port_sync_fifo_chk.sv
// Simulation-only request checker for the build without on-chip error
// detection: flags any push beyond free space or pop beyond occupancy.
module multi_port_sync_fifo_chk #(
  parameter int unsigned Depth     = 16,
  parameter int unsigned PushPorts = 2,
  parameter int unsigned PopPorts  = 2,
  localparam int unsigned CntWidth     = $clog2(Depth + 1),
  localparam int unsigned SumWidth     = CntWidth + 1,
  localparam int unsigned PushCntWidth = $clog2(PushPorts + 1),
  localparam int unsigned PopCntWidth  = $clog2(PopPorts + 1)
) (
  input logic                    clk,
  input logic                    rst,
  input logic                    flush_i,
  input logic [PushCntWidth-1:0] push_cnt_i,
  input logic [PopCntWidth-1:0]  pop_cnt_i,
  input logic [CntWidth-1:0]     used_cnt_i,
  input logic [CntWidth-1:0]     free_cnt_i
);

  // A push may only fill space that is free before the edge.
  property p_push_legal;
    @(posedge clk) disable iff (rst || flush_i)
      (SumWidth'(push_cnt_i) <= SumWidth'(free_cnt_i));
  endproperty

  // A pop may only take entries that are present before the edge.
  property p_pop_legal;
    @(posedge clk) disable iff (rst || flush_i)
      (SumWidth'(pop_cnt_i) <= SumWidth'(used_cnt_i));
  endproperty

  a_push_legal: assert property (p_push_legal)
    else $error("multi_port_sync_fifo: push_cnt_i exceeds free space");
  a_pop_legal: assert property (p_pop_legal)
    else $error("multi_port_sync_fifo: pop_cnt_i exceeds occupancy");

endmodule

// File: rtl/multi_port_sync_fifo.sv
// Synchronous FIFO accepting up to PushPorts writes and PopPorts reads per
// cycle, any Depth >= 2. Head data is read straight out of the storage
// registers, so a word is visible the cycle after it is pushed.
// Optional feature: define MULTI_PORT_SYNC_FIFO_ERR_CHECK_EN to add the
// sticky err_o output; illegal requests are then dropped in hardware.
module multi_port_sync_fifo
  import multi_port_sync_fifo_pkg::*;
#(
  parameter int unsigned Depth     = 16,
  parameter int unsigned WordWidth = 64,
  parameter int unsigned PushPorts = 2,
  parameter int unsigned PopPorts  = 2,
  localparam int unsigned PtrWidth     = $clog2(Depth),
  localparam int unsigned CntWidth     = $clog2(Depth + 1),
  localparam int unsigned PushCntWidth = $clog2(PushPorts + 1),
  localparam int unsigned PopCntWidth  = $clog2(PopPorts + 1)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                flush_i,
  input  logic [PushCntWidth-1:0]             push_cnt_i,
  input  logic [PushPorts-1:0][WordWidth-1:0] push_payload_i,
  input  logic [PopCntWidth-1:0]              pop_cnt_i,
  output logic [PopPorts-1:0][WordWidth-1:0]  pop_payload_o,
  output logic [PopPorts-1:0]                 pop_valid_o,
  output logic [CntWidth-1:0]                 used_cnt_o,
  output logic [CntWidth-1:0]                 free_cnt_o,
  output logic                                full_o,
  output logic                                empty_o
`ifdef MULTI_PORT_SYNC_FIFO_ERR_CHECK_EN
  ,
  output logic                                err_o
`endif
);

  localparam int unsigned SumWidth = CntWidth + 1;
  localparam logic [CntWidth-1:0] DepthCnt = CntWidth'(Depth);

  logic [PtrWidth-1:0]     head_ptr_s;
  logic [PtrWidth-1:0]     tail_ptr_s;
  logic [CntWidth-1:0]     used_r;
  logic [CntWidth-1:0]     free_s;
  logic [PushCntWidth-1:0] push_eff_s;
  logic [PopCntWidth-1:0]  pop_eff_s;
  logic [SumWidth-1:0]     sum_s;
  logic [CntWidth-1:0]     used_nxt_s;

  logic [WordWidth-1:0]    mem_r    [Depth];
  logic                    mem_we_s [Depth];
  logic [WordWidth-1:0]    mem_wd_s [Depth];
  logic [PtrWidth-1:0]     wr_idx_s [PushPorts];
  logic [PushPorts-1:0]    lane_en_s;
  logic [PtrWidth-1:0]     rd_idx_s [PopPorts];

  assign free_s = DepthCnt - used_r;

`ifdef MULTI_PORT_SYNC_FIFO_ERR_CHECK_EN
  logic       push_ok_s;
  logic       pop_ok_s;
  err_cause_e err_cause_s;
  logic       err_r;

  // Grant each request only if legal against pre-edge state; an illegal one
  // is dropped without blocking the other side.
  always_comb begin
    push_ok_s   = (SumWidth'(push_cnt_i) <= SumWidth'(free_s));
    pop_ok_s    = (SumWidth'(pop_cnt_i) <= SumWidth'(used_r));
    err_cause_s = NONE;
    if (!push_ok_s) begin
      err_cause_s = OVERFLOW;
    end else if (!pop_ok_s) begin
      err_cause_s = UNDERFLOW;
    end else begin
      err_cause_s = NONE;
    end
    if (rst || flush_i || !push_ok_s) begin
      push_eff_s = {PushCntWidth{1'b0}};
    end else begin
      push_eff_s = push_cnt_i;
    end
    if (rst || flush_i || !pop_ok_s) begin
      pop_eff_s = {PopCntWidth{1'b0}};
    end else begin
      pop_eff_s = pop_cnt_i;
    end
  end

  // Sticky error flag: set by any rejected request, cleared by reset or flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_r <= 1'b0;
    end else if (flush_i) begin
      err_r <= 1'b0;
    end else if (err_cause_s != NONE) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  assign err_o = err_r;
`else
  // Requests are trusted; only reset and flush suppress them.
  always_comb begin
    if (rst || flush_i) begin
      push_eff_s = {PushCntWidth{1'b0}};
      pop_eff_s  = {PopCntWidth{1'b0}};
    end else begin
      push_eff_s = push_cnt_i;
      pop_eff_s  = pop_cnt_i;
    end
  end

  multi_port_sync_fifo_chk #(
    .Depth     (Depth),
    .PushPorts (PushPorts),
    .PopPorts  (PopPorts)
  ) u_chk (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (flush_i),
    .push_cnt_i (push_cnt_i),
    .pop_cnt_i  (pop_cnt_i),
    .used_cnt_i (used_r),
    .free_cnt_i (free_s)
  );
`endif

  mpfifo_ptr_ctrl #(
    .Depth    (Depth),
    .AdvWidth (PopCntWidth)
  ) u_head (
    .clk     (clk),
    .rst     (rst),
    .flush_i (flush_i),
    .adv_i   (pop_eff_s),
    .ptr_o   (head_ptr_s)
  );

  mpfifo_ptr_ctrl #(
    .Depth    (Depth),
    .AdvWidth (PushCntWidth)
  ) u_tail (
    .clk     (clk),
    .rst     (rst),
    .flush_i (flush_i),
    .adv_i   (push_eff_s),
    .ptr_o   (tail_ptr_s)
  );

  // Occupancy update with one spare bit so push-then-pop never overflows.
  always_comb begin
    sum_s      = SumWidth'(used_r) + SumWidth'(push_eff_s) - SumWidth'(pop_eff_s);
    used_nxt_s = CntWidth'(sum_s);
  end

  // Occupancy register: reset and flush empty the FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      used_r <= {CntWidth{1'b0}};
    end else if (flush_i) begin
      used_r <= {CntWidth{1'b0}};
    end else begin
      used_r <= used_nxt_s;
    end
  end

  // Map each granted push lane to its entry: tail+k, wrapping past Depth-1.
  always_comb begin
    for (int k = 0; k < PushPorts; k++) begin
      wr_idx_s[k]  = PtrWidth'(ptr_advance(32'(tail_ptr_s), k, Depth));
      lane_en_s[k] = (PushCntWidth'(k) < push_eff_s);
    end
  end

  // Per-entry write decode; lanes always target distinct entries.
  always_comb begin
    for (int e = 0; e < Depth; e++) begin
      mem_we_s[e] = 1'b0;
      mem_wd_s[e] = push_payload_i[0];
      for (int k = 0; k < PushPorts; k++) begin
        mem_we_s[e] = mem_we_s[e] | (lane_en_s[k] && (wr_idx_s[k] == PtrWidth'(e)));
        mem_wd_s[e] = (lane_en_s[k] && (wr_idx_s[k] == PtrWidth'(e))) ?
                      push_payload_i[k] : mem_wd_s[e];
      end
    end
  end

  // Payload storage: written only for pushed entries, never cleared.
  always_ff @(posedge clk) begin
    for (int e = 0; e < Depth; e++) begin
      if (mem_we_s[e]) begin
        mem_r[e] <= mem_wd_s[e];
      end
    end
  end

  // Read lanes: entry head+k straight from storage, valid while occupied.
  always_comb begin
    for (int k = 0; k < PopPorts; k++) begin
      rd_idx_s[k]      = PtrWidth'(ptr_advance(32'(head_ptr_s), k, Depth));
      pop_payload_o[k] = mem_r[rd_idx_s[k]];
      pop_valid_o[k]   = (used_r > CntWidth'(k));
    end
  end

  assign used_cnt_o = used_r;
  assign free_cnt_o = free_s;
  assign full_o     = (used_r == DepthCnt);
  assign empty_o    = (used_r == {CntWidth{1'b0}});

endmodule

// File: tb/tb_multi_port_sync_fifo.sv
// Randomised bench for multi_port_sync_fifo (Depth=6, two push and two pop
// lanes) against a queue-based reference model, plus directed scenarios for
// wrap, full, simultaneous push/pop, flush and reset.
module tb_multi_port_sync_fifo;

  localparam int DEPTH = 6;
  localparam int W     = 16;

  logic               clk;
  logic               rst;
  logic               flush_i;
  logic [1:0]         push_cnt_i;
  logic [1:0][W-1:0]  push_payload_i;
  logic [1:0]         pop_cnt_i;
  logic [1:0][W-1:0]  pop_payload_o;
  logic [1:0]         pop_valid_o;
  logic [2:0]         used_cnt_o;
  logic [2:0]         free_cnt_o;
  logic               full_o;
  logic               empty_o;
`ifdef MULTI_PORT_SYNC_FIFO_ERR_CHECK_EN
  logic               err_o;
`endif

  multi_port_sync_fifo #(
    .Depth     (DEPTH),
    .WordWidth (W),
    .PushPorts (2),
    .PopPorts  (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .flush_i        (flush_i),
    .push_cnt_i     (push_cnt_i),
    .push_payload_i (push_payload_i),
    .pop_cnt_i      (pop_cnt_i),
    .pop_payload_o  (pop_payload_o),
    .pop_valid_o    (pop_valid_o),
    .used_cnt_o     (used_cnt_o),
    .free_cnt_o     (free_cnt_o),
    .full_o         (full_o),
    .empty_o        (empty_o)
`ifdef MULTI_PORT_SYNC_FIFO_ERR_CHECK_EN
    ,
    .err_o          (err_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0] model_q [$];
  bit           err_m;
  int           n_vec;
  int           n_err;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_state();
    logic [1:0] pv;
    int sz;
    sz = model_q.size();
    pv = {(sz > 1), (sz > 0)};
    chk("used_cnt", 64'(used_cnt_o), 64'(sz));
    chk("free_cnt", 64'(free_cnt_o), 64'(DEPTH - sz));
    chk("full", 64'(full_o), 64'(sz == DEPTH));
    chk("empty", 64'(empty_o), 64'(sz == 0));
    chk("pop_valid", 64'(pop_valid_o), 64'(pv));
    for (int k = 0; k < 2; k++) begin
      if (k < sz) begin
        chk("pop_payload", 64'(pop_payload_o[k]), 64'(model_q[k]));
      end
    end
`ifdef MULTI_PORT_SYNC_FIFO_ERR_CHECK_EN
    chk("err", 64'(err_o), 64'(err_m));
`endif
  endtask

  // Apply one cycle of requests, update the model, then check all outputs.
  task automatic step(input int pn, input int qn, input bit fl, input bit rs,
                      input logic [W-1:0] d0, input logic [W-1:0] d1);
    bit push_ok;
    bit pop_ok;
    rst               = rs;
    flush_i           = fl;
    push_cnt_i        = 2'(pn);
    pop_cnt_i         = 2'(qn);
    push_payload_i[0] = d0;
    push_payload_i[1] = d1;
    @(posedge clk);
    if (rs || fl) begin
      model_q.delete();
      err_m = 1'b0;
    end else begin
      push_ok = (pn <= DEPTH - model_q.size());
      pop_ok  = (qn <= model_q.size());
      if (!push_ok || !pop_ok) err_m = 1'b1;
      if (pop_ok) begin
        for (int i = 0; i < qn; i++) void'(model_q.pop_front());
      end
      if (push_ok) begin
        if (pn > 0) model_q.push_back(d0);
        if (pn > 1) model_q.push_back(d1);
      end
    end
    #1;
    check_state();
  endtask

  task automatic go(input int pn, input int qn);
    step(pn, qn, 1'b0, 1'b0, W'($urandom), W'($urandom));
  endtask

  initial begin
    int  used_m;
    int  free_m;
    int  pn;
    int  qn;
    bit  fl;
    bit  rs;
    n_vec = 0;
    n_err = 0;
    err_m = 1'b0;
    rst = 1'b1;
    flush_i = 1'b0;
    push_cnt_i = 2'd0;
    pop_cnt_i = 2'd0;
    push_payload_i = '0;

    // Reset state
    step(0, 0, 1'b0, 1'b1, 16'h0, 16'h0);
    chk("reset_empty", 64'(empty_o), 64'd1);
    chk("reset_free", 64'(free_cnt_o), 64'(DEPTH));

    // Walk head and tail to entry 5, then push across the wrap point
    go(2, 0); go(2, 0); go(1, 0);
    go(0, 2); go(0, 2); go(0, 1);
    step(2, 0, 1'b0, 1'b0, 16'hA0A0, 16'hB0B0);
    chk("wrap_lane0", 64'(pop_payload_o[0]), 64'h A0A0);
    chk("wrap_lane1", 64'(pop_payload_o[1]), 64'h B0B0);
    chk("wrap_valid", 64'(pop_valid_o), 64'd3);

    // Simultaneous push 2 / pop 2 at occupancy 3, then drain in order
    go(1, 0);
    go(2, 2);
    chk("simul_used", 64'(used_cnt_o), 64'd3);
    go(0, 2); go(0, 1);

    // Fill to full with three double pushes
    step(0, 0, 1'b0, 1'b1, 16'h0, 16'h0);
    go(2, 0); go(2, 0); go(2, 0);
    chk("fill_full", 64'(full_o), 64'd1);
    chk("fill_used", 64'(used_cnt_o), 64'd6);
    chk("fill_free", 64'(free_cnt_o), 64'd0);

    // Flush overrides a same-cycle push
    go(0, 2);
    step(2, 0, 1'b1, 1'b0, 16'h1111, 16'h2222);
    chk("flush_empty", 64'(empty_o), 64'd1);
    chk("flush_used", 64'(used_cnt_o), 64'd0);

    // Reset with four entries stored
    go(2, 0); go(2, 0);
    step(0, 0, 1'b0, 1'b1, 16'h0, 16'h0);
    chk("rst_empty", 64'(empty_o), 64'd1);
    chk("rst_free", 64'(free_cnt_o), 64'(DEPTH));

`ifdef MULTI_PORT_SYNC_FIFO_ERR_CHECK_EN
    // Overflowing push is dropped and latches err_o until flush
    go(2, 0); go(2, 0); go(1, 0);
    go(2, 0);
    chk("ovf_err", 64'(err_o), 64'd1);
    chk("ovf_used", 64'(used_cnt_o), 64'd5);
    step(0, 0, 1'b1, 1'b0, 16'h0, 16'h0);
    chk("ovf_clear", 64'(err_o), 64'd0);
`endif

    // Random legal traffic with occasional flush and reset
    for (int i = 0; i < 400; i++) begin
      used_m = model_q.size();
      free_m = DEPTH - used_m;
      pn = int'($urandom_range(0, (free_m < 2) ? free_m : 2));
      qn = int'($urandom_range(0, (used_m < 2) ? used_m : 2));
`ifdef MULTI_PORT_SYNC_FIFO_ERR_CHECK_EN
      if ($urandom_range(0, 9) == 0) begin
        pn = int'($urandom_range(0, 2));
        qn = int'($urandom_range(0, 2));
      end
`endif
      fl = ($urandom_range(0, 19) == 0);
      rs = ($urandom_range(0, 49) == 0);
      step(pn, qn, fl, rs, W'($urandom), W'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
